// File: rtl/osc_reset_gen_if.sv
// Board-side control/status bundle of osc_reset_gen: standby and reset requests in,
// divided oscillator, strobe and combined system reset out.
interface osc_reset_gen_if;
  logic stdby;
  logic gsr_n;
  logic pur_n;
  logic osc;
  logic osc_tick;
  logic sedstdby;
  logic pur_busy;
  logic sys_rst;

  modport master (
    output stdby, gsr_n, pur_n,
    input  osc, osc_tick, sedstdby, pur_busy, sys_rst
  );

  modport slave (
    input  stdby, gsr_n, pur_n,
    output osc, osc_tick, sedstdby, pur_busy, sys_rst
  );
endinterface

// File: rtl/osc_reset_gen.sv
// Clock/reset housekeeping: osc divider, power-up reset stretcher, gsr/pur synchronizers
// and registered system reset. Define OSC_RST_GATE_EN to hold the divider while sys_rst=1.
module osc_reset_gen #(
  parameter int DIV_HALF    = 2,
  parameter int PUR_CYCLES  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         crystal_osc,
  input  logic         reset,
  osc_reset_gen_if.slave bus
);

  localparam int DIV_W = $clog2(DIV_HALF) + 1;
  localparam int PUR_W = (PUR_CYCLES > 0) ? $clog2(PUR_CYCLES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [PUR_W-1:0] PUR_LOAD = PUR_W'(PUR_CYCLES);

  logic [DIV_W-1:0]       div_cnt;
  logic                   osc_r;
  logic                   osc_tick_r;
  logic                   sedstdby_r;
  logic [SYNC_STAGES-1:0] gsr_sync;
  logic [SYNC_STAGES-1:0] pur_sync;
  logic [PUR_W-1:0]       pur_cnt;
  logic                   sys_rst_r;
  logic                   gsr_s;
  logic                   pur_s;
  logic                   pur_busy;
  logic                   div_hold;

  function automatic logic [PUR_W-1:0] sat_dec(input logic [PUR_W-1:0] v);
    return (v == '0) ? v : v - PUR_W'(1);
  endfunction

  assign gsr_s    = gsr_sync[SYNC_STAGES-1];
  assign pur_s    = pur_sync[SYNC_STAGES-1];
  assign pur_busy = (pur_cnt != '0);

`ifdef OSC_RST_GATE_EN
  assign div_hold = bus.stdby | sys_rst_r;
`else
  assign div_hold = bus.stdby;
`endif

  // Divider: osc toggles on the terminal count; the strobe marks only the 0->1 edge.
  always_ff @(posedge crystal_osc) begin
    if (reset || div_hold) begin
      div_cnt    <= '0;
      osc_r      <= 1'b0;
      osc_tick_r <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      osc_r      <= ~osc_r;
      osc_tick_r <= ~osc_r;
    end else begin
      div_cnt    <= div_cnt + DIV_W'(1);
      osc_tick_r <= 1'b0;
    end
  end

  // Synchronizers reset to "gsr requested, pur idle" so sys_rst holds until gsr_n is seen high.
  always_ff @(posedge crystal_osc) begin
    if (reset) begin
      gsr_sync   <= '0;
      pur_sync   <= '1;
      sedstdby_r <= 1'b0;
    end else begin
      gsr_sync   <= {gsr_sync[SYNC_STAGES-2:0], bus.gsr_n};
      pur_sync   <= {pur_sync[SYNC_STAGES-2:0], bus.pur_n};
      sedstdby_r <= bus.stdby;
    end
  end

  // Power-up stretch and combined reset register.
  always_ff @(posedge crystal_osc) begin
    if (reset) begin
      pur_cnt   <= PUR_LOAD;
      sys_rst_r <= 1'b1;
    end else begin
      pur_cnt   <= pur_s ? sat_dec(pur_cnt) : PUR_LOAD;
      sys_rst_r <= pur_busy | ~gsr_s;
    end
  end

  assign bus.osc      = osc_r;
  assign bus.osc_tick = osc_tick_r;
  assign bus.sedstdby = sedstdby_r;
  assign bus.pur_busy = pur_busy;
  assign bus.sys_rst  = sys_rst_r;

endmodule

// File: tb/tb_osc_reset_gen.sv
// Directed bench for osc_reset_gen: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_osc_reset_gen;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  osc_reset_gen_if bus();

  osc_reset_gen #(
    .DIV_HALF(2),
    .PUR_CYCLES(16),
    .SYNC_STAGES(2)
  ) dut (
    .crystal_osc(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_OSC, S_TICK, S_SED, S_BUSY, S_RST, S_CNT} sig_e;
  typedef struct {
    int   cyc;
    sig_e sig;
    int   val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int sample(input sig_e s);
    case (s)
      S_OSC:   return int'(bus.osc);
      S_TICK:  return int'(bus.osc_tick);
      S_SED:   return int'(bus.sedstdby);
      S_BUSY:  return int'(bus.pur_busy);
      S_RST:   return int'(bus.sys_rst);
      default: return int'(dut.pur_cnt);
    endcase
  endfunction

  // Keep the queue ordered by cycle so the monitor only ever looks at the head.
  task automatic expect_at(input int c, input sig_e s, input int v);
    exp_t e;
    int   pos;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  task automatic go_after(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   got;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      got = sample(e.sig);
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s missed at cyc %0d (now %0d): required %0d", e.sig.name(), e.cyc, cyc, e.val);
      end else if (got != e.val) begin
        n_fail++;
        $display("FAIL %s at cyc %0d: got %0d required %0d", e.sig.name(), cyc, got, e.val);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.stdby = 1'b0;
    bus.gsr_n = 1'b1;
    bus.pur_n = 1'b1;

    // reset state after two reset edges
    expect_at(2, S_OSC, 0);  expect_at(2, S_TICK, 0); expect_at(2, S_SED, 0);
    expect_at(2, S_BUSY, 1); expect_at(2, S_RST, 1);  expect_at(2, S_CNT, 16);

    // 1) release: osc rises 2 edges later, period 4; sys_rst falls 17 edges later
    expect_at(3, S_OSC, 0);
    expect_at(10, S_CNT, 8);
    expect_at(17, S_BUSY, 1); expect_at(17, S_RST, 1);
    expect_at(18, S_BUSY, 0); expect_at(18, S_RST, 1); expect_at(18, S_CNT, 0);
    expect_at(19, S_RST, 0);
`ifdef OSC_RST_GATE_EN
    expect_at(4, S_OSC, 0);   expect_at(8, S_OSC, 0);
    expect_at(19, S_OSC, 0);  expect_at(20, S_OSC, 0);
    expect_at(21, S_OSC, 1);  expect_at(21, S_TICK, 1);
    expect_at(22, S_TICK, 0);
`else
    expect_at(4, S_OSC, 1);   expect_at(4, S_TICK, 1);
    expect_at(5, S_OSC, 1);   expect_at(5, S_TICK, 0);
    expect_at(6, S_OSC, 0);
    expect_at(8, S_OSC, 1);   expect_at(8, S_TICK, 1);
    expect_at(20, S_OSC, 1);  expect_at(20, S_TICK, 1);
    expect_at(21, S_OSC, 1);  expect_at(21, S_TICK, 0);
    expect_at(28, S_OSC, 1);
`endif
    go_after(2);
    reset = 1'b0;

    // 2) standby for 10 clocks
    expect_at(29, S_OSC, 0); expect_at(29, S_TICK, 0); expect_at(29, S_SED, 1);
    expect_at(33, S_OSC, 0);
    expect_at(38, S_SED, 1);
    expect_at(39, S_SED, 0); expect_at(39, S_OSC, 0);
    expect_at(40, S_OSC, 1); expect_at(40, S_TICK, 1);
    expect_at(41, S_OSC, 1); expect_at(41, S_TICK, 0);
    expect_at(42, S_OSC, 0);
    go_after(28);
    bus.stdby = 1'b1;
    go_after(38);
    bus.stdby = 1'b0;

    // 3) pur_n low for 5 clocks
    expect_at(52, S_BUSY, 0); expect_at(52, S_RST, 0);
    expect_at(53, S_BUSY, 1); expect_at(53, S_CNT, 16); expect_at(53, S_RST, 0);
    expect_at(54, S_RST, 1);
    expect_at(57, S_CNT, 16);
    expect_at(58, S_CNT, 15);
    expect_at(72, S_BUSY, 1); expect_at(72, S_RST, 1);
    expect_at(73, S_BUSY, 0); expect_at(73, S_CNT, 0); expect_at(73, S_RST, 1);
    expect_at(74, S_RST, 0);
    go_after(50);
    bus.pur_n = 1'b0;
    go_after(55);
    bus.pur_n = 1'b1;

    // 4) gsr_n low for 4 clocks
    expect_at(82, S_RST, 0);
    expect_at(83, S_RST, 1);
    expect_at(85, S_BUSY, 0); expect_at(85, S_CNT, 0);
    expect_at(86, S_RST, 1);
    expect_at(87, S_RST, 0);
    go_after(80);
    bus.gsr_n = 1'b0;
    go_after(84);
    bus.gsr_n = 1'b1;

    // 5) reset pulse while pur_cnt=8
    expect_at(104, S_CNT, 8); expect_at(104, S_RST, 1);
    expect_at(105, S_OSC, 0); expect_at(105, S_TICK, 0); expect_at(105, S_CNT, 16);
    expect_at(105, S_RST, 1); expect_at(105, S_BUSY, 1);
    expect_at(121, S_RST, 1);
    expect_at(122, S_RST, 0);
`ifdef OSC_RST_GATE_EN
    expect_at(122, S_OSC, 0); expect_at(123, S_OSC, 0);
    expect_at(124, S_OSC, 1); expect_at(124, S_TICK, 1);
`else
    expect_at(104, S_OSC, 1);
    expect_at(107, S_OSC, 1); expect_at(107, S_TICK, 1);
`endif
    go_after(91);
    bus.pur_n = 1'b0;
    go_after(94);
    bus.pur_n = 1'b1;
    go_after(104);
    reset = 1'b1;
    go_after(105);
    reset = 1'b0;

    go_after(128);
    while (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked (cyc %0d): required %0d", q[0].sig.name(), q[0].cyc, q[0].val);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
